// File: rtl/hex_display_scan_if.sv
// Hex display scanner bus: host-side value/load/dp/enable inputs
// and registered LED drive outputs (segments, dp, anodes, frame).
interface hex_display_scan_if #(
  parameter int NDIGITS = 4
);
  logic [4*NDIGITS-1:0] value_i;
  logic                 load_i;
  logic [NDIGITS-1:0]   dp_i;
  logic                 en_i;
  logic [0:6]           seg_o;
  logic                 dp_o;
  logic [NDIGITS-1:0]   an_o;
  logic                 frame_o;

  modport master (
    output value_i, load_i, dp_i, en_i,
    input  seg_o, dp_o, an_o, frame_o
  );

  modport slave (
    input  value_i, load_i, dp_i, en_i,
    output seg_o, dp_o, an_o, frame_o
  );
endinterface

// File: rtl/hex_display_scan.sv
// Multiplexed 7-seg hex scanner: clk, rst_n (async low), bus (slave).
// HEX_SCAN_BLANK_EN: blank leading-zero digits above digit 0.
module hex_display_scan #(
  parameter int NDIGITS = 4,
  parameter int DIV     = 50000
) (
  input  logic clk,
  input  logic rst_n,
  hex_display_scan_if.slave bus
);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(NDIGITS - 1);

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [4*NDIGITS-1:0] val_q, val_d;
  logic [NDIGITS-1:0]   dps_q, dps_d;
  logic [0:6]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic [NDIGITS-1:0]   an_q, an_d;
  logic                 frame_q, frame_d;

  logic       tick;
  logic [3:0] nib;
  logic       dpb;
  logic       zblank;

  function automatic logic [0:6] decode(input logic [3:0] n);
    logic [0:6] s;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0001100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

`ifdef HEX_SCAN_BLANK_EN
  // lz[k]: nibble k and everything above it are zero
  logic [NDIGITS:0] lz;
  always_comb begin
    lz = '0;
    lz[NDIGITS] = 1'b1;
    for (int k = NDIGITS - 1; k >= 0; k--)
      lz[k] = lz[k+1] && (val_q[4*k +: 4] == 4'h0);
  end
`endif

  always_comb begin
    tick  = (cnt_q == CMAX);
    cnt_d = tick ? '0 : cnt_q + CW'(1);

    idx_d = idx_q;
    if (tick)
      idx_d = (idx_q == IMAX) ? '0 : idx_q + IW'(1);
    frame_d = tick && (idx_d == '0);

    val_d = bus.load_i ? bus.value_i : val_q;
    dps_d = bus.load_i ? bus.dp_i : dps_q;

    // Decode from the pre-load shadow so a coincident load
    // only shows up from the following slot.
    nib    = 4'h0;
    dpb    = 1'b0;
    zblank = 1'b0;
    for (int k = 0; k < NDIGITS; k++) begin
      if (idx_d == IW'(k)) begin
        nib = val_q[4*k +: 4];
        dpb = dps_q[k];
`ifdef HEX_SCAN_BLANK_EN
        zblank = (k != 0) && lz[k];
`endif
      end
    end

    an_d  = an_q;
    seg_d = seg_q;
    dp_d  = dp_q;
    if (!bus.en_i) begin
      an_d  = '1;
      seg_d = '1;
      dp_d  = 1'b1;
    end else if (tick) begin
      an_d = '1;
      for (int k = 0; k < NDIGITS; k++)
        if (idx_d == IW'(k)) an_d[k] = 1'b0;
      seg_d = zblank ? 7'b1111111 : decode(nib);
      dp_d  = ~dpb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= IMAX;
      val_q   <= '0;
      dps_q   <= '0;
      seg_q   <= '1;
      dp_q    <= 1'b1;
      an_q    <= '1;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      dps_q   <= dps_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  assign bus.seg_o   = seg_q;
  assign bus.dp_o    = dp_q;
  assign bus.an_o    = an_q;
  assign bus.frame_o = frame_q;
endmodule

// File: tb/tb_hex_display_scan.sv
// Self-checking bench for hex_display_scan (NDIGITS=4, DIV=4)
// against an event-level model of the scanner.
module tb_hex_display_scan;
  localparam int N   = 4;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hex_display_scan_if #(.NDIGITS(N)) bus ();

  hex_display_scan #(.NDIGITS(N), .DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int nchecks = 0;
  int nfail   = 0;

  logic [0:6] tbl [16];
  int          e;
  logic [15:0] sh_v;
  logic [3:0]  sh_dp;
  logic [3:0]  exp_an;
  logic [0:6]  exp_seg;
  logic        exp_dp;
  logic        exp_frame;

  initial begin
    tbl[0]  = 7'b0000001; tbl[1]  = 7'b1001111;
    tbl[2]  = 7'b0010010; tbl[3]  = 7'b0000110;
    tbl[4]  = 7'b1001100; tbl[5]  = 7'b0100100;
    tbl[6]  = 7'b0100000; tbl[7]  = 7'b0001111;
    tbl[8]  = 7'b0000000; tbl[9]  = 7'b0001100;
    tbl[10] = 7'b0001000; tbl[11] = 7'b1100000;
    tbl[12] = 7'b0110001; tbl[13] = 7'b1000010;
    tbl[14] = 7'b0110000; tbl[15] = 7'b0111000;
  end

  task automatic model_reset();
    e = 0;
    sh_v = '0;
    sh_dp = '0;
    exp_an = '1;
    exp_seg = 7'b1111111;
    exp_dp = 1'b1;
    exp_frame = 1'b0;
  endtask

  // One clock edge; model follows from edge count since reset.
  task automatic cycle();
    bit tk;
    int k;
    bit blank;
    @(posedge clk);
    if (rst_n) begin
      e++;
      tk = (e % DIV) == 0;
      k = ((e / DIV) - 1) % N;
      exp_frame = tk && (k == 0);
      if (!bus.en_i) begin
        exp_an = '1;
        exp_seg = 7'b1111111;
        exp_dp = 1'b1;
      end else if (tk) begin
        blank = 1'b0;
`ifdef HEX_SCAN_BLANK_EN
        blank = (k >= 1) && ((sh_v >> (4 * k)) == 0);
`endif
        exp_an = ~(4'b0001 << k);
        exp_seg = blank ? 7'b1111111 : tbl[(sh_v >> (4 * k)) & 15];
        exp_dp = ~sh_dp[k];
      end
      if (bus.load_i) begin
        sh_v = bus.value_i;
        sh_dp = bus.dp_i;
      end
    end
    #1;
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] d);
    bus.value_i = v;
    bus.dp_i = d;
    bus.load_i = 1'b1;
    cycle();
    bus.load_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.en_i = 1'b1;
    bus.load_i = 1'b0;
    bus.value_i = '0;
    bus.dp_i = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) cycle();
    nchecks++;
    if (bus.an_o !== 4'b1111) begin
      nfail++;
      $display("FAIL reset_an got=%b exp=1111", bus.an_o);
    end
    nchecks++;
    if (bus.seg_o !== 7'b1111111) begin
      nfail++;
      $display("FAIL reset_seg got=%b exp=1111111", bus.seg_o);
    end
    nchecks++;
    if (bus.dp_o !== 1'b1 || bus.frame_o !== 1'b0) begin
      nfail++;
      $display("FAIL reset_dp_frame got=%b%b exp=10",
               bus.dp_o, bus.frame_o);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= DIV + 1; i++) begin
      cycle();
      nchecks++;
      if ({bus.an_o, bus.seg_o, bus.dp_o, bus.frame_o} !==
          {exp_an, exp_seg, exp_dp, exp_frame}) begin
        nfail++;
        $display("FAIL reset_release c%0d got=%b/%b/%b/%b exp=%b/%b/%b/%b",
                 i, bus.an_o, bus.seg_o, bus.dp_o, bus.frame_o,
                 exp_an, exp_seg, exp_dp, exp_frame);
      end
      if (i == DIV) begin
        nchecks++;
        if (bus.an_o !== 4'b1110 || bus.frame_o !== 1'b1) begin
          nfail++;
          $display("FAIL first_tick got an=%b fr=%b exp an=1110 fr=1",
                   bus.an_o, bus.frame_o);
        end
      end
    end
  endtask

  task automatic test_scan();
    load(16'h12AF, 4'b0000);
    for (int i = 0; i < 2 * N * DIV; i++) begin
      cycle();
      nchecks++;
      if ({bus.an_o, bus.seg_o, bus.dp_o, bus.frame_o} !==
          {exp_an, exp_seg, exp_dp, exp_frame}) begin
        nfail++;
        $display("FAIL scan e%0d got=%b/%b/%b/%b exp=%b/%b/%b/%b",
                 e, bus.an_o, bus.seg_o, bus.dp_o, bus.frame_o,
                 exp_an, exp_seg, exp_dp, exp_frame);
      end
      if (bus.an_o === 4'b1011) begin
        nchecks++;
        if (bus.seg_o !== 7'b0010010) begin
          nfail++;
          $display("FAIL scan_digit2 got=%b exp=0010010", bus.seg_o);
        end
      end
    end
  endtask

  task automatic test_load_tick();
    for (int i = 0; i < N * DIV && (e % (N * DIV)) != DIV; i++)
      cycle();
    cycle();
    load(16'h8888, 4'b0000);
    for (int i = 0; i < N * DIV; i++) begin
      cycle();
      nchecks++;
      if ({bus.an_o, bus.seg_o, bus.dp_o, bus.frame_o} !==
          {exp_an, exp_seg, exp_dp, exp_frame}) begin
        nfail++;
        $display("FAIL load_mid e%0d got=%b/%b exp=%b/%b",
                 e, bus.an_o, bus.seg_o, exp_an, exp_seg);
      end
    end
    for (int i = 0; i < DIV && ((e + 1) % DIV) != 0; i++)
      cycle();
    load(16'h3333, 4'b0000);
    nchecks++;
    if (bus.seg_o !== 7'b0000000) begin
      nfail++;
      $display("FAIL load_on_tick got=%b exp=0000000", bus.seg_o);
    end
    for (int i = 0; i < N * DIV; i++) begin
      cycle();
      nchecks++;
      if ({bus.an_o, bus.seg_o, bus.dp_o, bus.frame_o} !==
          {exp_an, exp_seg, exp_dp, exp_frame}) begin
        nfail++;
        $display("FAIL load_tick_after e%0d got=%b/%b exp=%b/%b",
                 e, bus.an_o, bus.seg_o, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_enable();
    int frames;
    while ((e % DIV) != 1) cycle();
    bus.en_i = 1'b0;
    cycle();
    nchecks++;
    if (bus.an_o !== 4'b1111 || bus.seg_o !== 7'b1111111) begin
      nfail++;
      $display("FAIL disable_blank got an=%b seg=%b exp 1111/1111111",
               bus.an_o, bus.seg_o);
    end
    frames = 0;
    for (int i = 0; i < 2 * N * DIV; i++) begin
      cycle();
      if (bus.frame_o === 1'b1) frames++;
      nchecks++;
      if ({bus.an_o, bus.seg_o, bus.dp_o, bus.frame_o} !==
          {exp_an, exp_seg, exp_dp, exp_frame}) begin
        nfail++;
        $display("FAIL disabled e%0d got=%b/%b/%b exp=%b/%b/%b",
                 e, bus.an_o, bus.seg_o, bus.frame_o,
                 exp_an, exp_seg, exp_frame);
      end
    end
    nchecks++;
    if (frames != 2) begin
      nfail++;
      $display("FAIL disabled_frames got=%0d exp=2", frames);
    end
    while ((e % DIV) != 1) cycle();
    bus.en_i = 1'b1;
    for (int i = 0; i < N * DIV; i++) begin
      cycle();
      nchecks++;
      if ({bus.an_o, bus.seg_o, bus.dp_o, bus.frame_o} !==
          {exp_an, exp_seg, exp_dp, exp_frame}) begin
        nfail++;
        $display("FAIL reenable e%0d got=%b/%b exp=%b/%b",
                 e, bus.an_o, bus.seg_o, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_dp();
    load(16'h0000, 4'b0100);
    for (int i = 0; i < 2 * N * DIV; i++) begin
      cycle();
      nchecks++;
      if ({bus.an_o, bus.dp_o} !== {exp_an, exp_dp}) begin
        nfail++;
        $display("FAIL dp e%0d got an=%b dp=%b exp an=%b dp=%b",
                 e, bus.an_o, bus.dp_o, exp_an, exp_dp);
      end
    end
  endtask

  task automatic test_blank();
    load(16'h0005, 4'b0000);
    for (int i = 0; i < 2 * N * DIV; i++) begin
      cycle();
      nchecks++;
      if ({bus.an_o, bus.seg_o} !== {exp_an, exp_seg}) begin
        nfail++;
        $display("FAIL blank e%0d got=%b/%b exp=%b/%b",
                 e, bus.an_o, bus.seg_o, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bus.value_i = 16'($urandom);
      bus.dp_i = 4'($urandom);
      bus.load_i = ($urandom_range(0, 5) == 0);
      bus.en_i = ($urandom_range(0, 9) != 0);
      cycle();
      nchecks++;
      if ({bus.an_o, bus.seg_o, bus.dp_o, bus.frame_o} !==
          {exp_an, exp_seg, exp_dp, exp_frame}) begin
        nfail++;
        $display("FAIL random e%0d got=%b/%b/%b/%b exp=%b/%b/%b/%b",
                 e, bus.an_o, bus.seg_o, bus.dp_o, bus.frame_o,
                 exp_an, exp_seg, exp_dp, exp_frame);
      end
    end
    bus.load_i = 1'b0;
    bus.en_i = 1'b1;
  endtask

  task automatic test_reset_mid();
    load(16'h9BCD, 4'b1111);
    repeat (N * DIV + 2) cycle();
    rst_n = 1'b0;
    model_reset();
    #1;
    nchecks++;
    if ({bus.an_o, bus.seg_o, bus.dp_o, bus.frame_o} !==
        {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
      nfail++;
      $display("FAIL reset_mid got=%b/%b/%b/%b exp=1111/1111111/1/0",
               bus.an_o, bus.seg_o, bus.dp_o, bus.frame_o);
    end
    repeat (2) cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3 * N * DIV; i++) begin
      cycle();
      nchecks++;
      if ({bus.an_o, bus.seg_o, bus.dp_o, bus.frame_o} !==
          {exp_an, exp_seg, exp_dp, exp_frame}) begin
        nfail++;
        $display("FAIL after_reset e%0d got=%b/%b/%b/%b exp=%b/%b/%b/%b",
                 e, bus.an_o, bus.seg_o, bus.dp_o, bus.frame_o,
                 exp_an, exp_seg, exp_dp, exp_frame);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load_tick();
    test_enable();
    test_dp();
    test_blank();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end
endmodule

// File: doc/hex_display_scan.md
HEX_DISPLAY_SCAN -- requirements
Module: hex_display_scan

Interface
REQ-001 Parameter NDIGITS, default 4: number of multiplexed digits; legal range 1..8.
REQ-002 Parameter DIV, default 50000: clock cycles per digit slot; legal range >= 2.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 value_i  input  4*NDIGITS  hex value; digit k = value_i[4k+3:4k]; digit 0 least significant.
REQ-006 load_i  input  1  when high at a rising edge, value_i and dp_i SHALL be captured into the shadow registers.
REQ-007 dp_i  input  NDIGITS  decimal-point request per digit, 1 = lit.
REQ-008 en_i  input  1  display enable; 0 = blank the display.
REQ-009 seg_o  output  [0:6]  registered segments a..g (bit 0 = a), active-low.
REQ-010 dp_o  output  1  registered decimal point, active-low.
REQ-011 an_o  output  NDIGITS  registered digit select, active-low, one-hot when enabled.
REQ-012 frame_o  output  1  one-cycle pulse on every entry to digit 0.

Function
REQ-013 The prescaler SHALL count 0..DIV-1 and wrap; the wrap cycle is the slot tick, so each slot lasts exactly DIV cycles.
REQ-014 On each tick, idx SHALL advance by 1, wrapping NDIGITS-1 -> 0; one frame = NDIGITS*DIV cycles.
REQ-015 On the tick edge, idx, an_o, seg_o and dp_o SHALL update together; an_o has bit [new idx] = 0 and all other bits 1.
REQ-016 Between ticks, an_o, seg_o and dp_o SHALL hold, regardless of load_i.
REQ-017 frame_o SHALL be 1 for exactly the cycle after the edge on which idx becomes 0, and 0 otherwise.
REQ-018 seg_o SHALL be decoded from the shadow nibble of the new digit: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-019 dp_o SHALL equal the inverse of the shadow dp bit of the new digit.
REQ-020 Load and tick on the same edge: the tick SHALL decode the pre-load shadow; the new value SHALL appear from the next tick onward.
REQ-021 en_i = 0 sampled at any edge: on that edge, an_o SHALL become all 1s, seg_o 1111111 and dp_o 1; the prescaler, idx and frame_o continue unaffected.
REQ-022 en_i returning to 1: the outputs SHALL stay blank until the next tick, then resume normal scanning.
REQ-023 NDIGITS = 1: an_o SHALL be 0 after every tick, and frame_o SHALL pulse every DIV cycles.

Reset
REQ-024 While rst_n = 0: prescaler = 0, idx = NDIGITS-1, shadow value = 0, shadow dp = 0, an_o = all 1s, seg_o = 1111111, dp_o = 1, frame_o = 0.
REQ-025 Reset assertion mid-slot or mid-frame SHALL take effect immediately, with no completion of the current slot.
REQ-026 After rst_n rises, the first tick SHALL occur DIV cycles later and select digit 0, with a frame_o pulse.

Configuration
REQ-027 Macro HEX_SCAN_BLANK_EN defined: any digit k >= 1 whose shadow nibble and all more-significant shadow nibbles are 0 SHALL drive seg_o = 1111111.
REQ-028 Under the same macro, an_o and dp_o for blanked digits SHALL behave as in REQ-015 and REQ-019, and digit 0 SHALL never be blanked.
REQ-029 Macro HEX_SCAN_BLANK_EN undefined: every digit SHALL be decoded per REQ-018, and the blanking logic SHALL be absent.

Verification
REQ-030 NDIGITS=4, DIV=4, rst_n held low -> an_o=1111, seg_o=1111111, frame_o=0; 4 cycles after release -> an_o=1110 and a 1-cycle frame_o pulse.
REQ-031 Load 16'h12AF -> successive slots give (an_o, seg_o) = (1110, 0111000), (1101, 0001000), (1011, 0010010), (0111, 1001111), then repeat.
REQ-032 Load 16'h8888 two cycles into a digit-0 slot -> seg_o unchanged until the tick, then 0000000 from digit 1 on; load coincident with a tick -> old digit shown for that slot.
REQ-033 en_i=0 mid-slot -> an_o=1111 on the next edge, frame_o period still 16 cycles; en_i=1 -> blank until the next tick, then the correct digit.
REQ-034 Load 16'h0005 -> with HEX_SCAN_BLANK_EN, digits 1..3 show 1111111 and digit 0 shows 0100100; without it, digits 1..3 show 0000001.
REQ-035 dp_i=4'b0100 loaded -> dp_o=0 only while an_o=1011, dp_o=1 in all other slots.
